// File: rtl/softmax_pkg.sv
// Shared types and width helpers for the streaming softmax engine.
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAX,
    EXP,
    DIV,
    OUT
  } state_e;

  // Denominator width: N values of at most 2^E each, so no overflow is possible.
  function automatic int den_width(input int n, input int e);
    return e + 1 + $clog2(n);
  endfunction

  // Element index width, at least one bit so N=1 still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones value of an ow-bit probability, used when the quotient reaches 1.0.
  function automatic logic [63:0] sat_value(input int ow);
    return (64'd1 << ow) - 64'd1;
  endfunction

endpackage

// File: rtl/softmax_div_serial.sv
// Restoring divider computing (num * 2^QW) / den, one quotient bit per cycle.
// The load cycle resolves the integer bit; QW cycles follow for the fraction.
// done is high in the final iteration cycle and quo already carries that bit.
module softmax_div_serial
  import softmax_pkg::*;
#(
  parameter int NW = 17,
  parameter int DW = 20,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quo
);

  localparam int CW = $clog2(QW + 1);

  logic [DW-1:0] rem_q, rem_d;
  logic [QW-1:0] q_q, q_d;
  logic          msb_q, msb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [DW:0]   sh;
  logic [DW:0]   sh_sub;
  logic          ge;
  logic [QW-1:0] q_step;
  logic [DW-1:0] num_ext;

  // Load on start, then one shift-subtract step per cycle until the counter expires.
  always_comb begin
    num_ext = DW'(num);
    sh      = {rem_q, 1'b0};
    ge      = (sh >= {1'b0, den});
    sh_sub  = sh - {1'b0, den};
    q_step  = {q_q[QW-2:0], ge};
    rem_d   = rem_q;
    q_d     = q_q;
    msb_d   = msb_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      msb_d  = (num_ext >= den);
      rem_d  = (num_ext >= den) ? (num_ext - den) : num_ext;
      q_d    = '0;
      cnt_d  = CW'(QW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? sh_sub[DW-1:0] : sh[DW-1:0];
      q_d   = q_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      msb_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      msb_q  <= msb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quo  = msb_q ? QW'(sat_value(QW)) : q_step;

endmodule

// File: rtl/softmax_stream.sv
// Sequential base-2 softmax: max scan, exponent pass, then one serial divide
// per output element, streamed out with backpressure.
//   state | meaning
//   IDLE  | waiting for an input vector
//   MAX   | scanning for the largest element, one per cycle
//   EXP   | computing 2^(x-max) per element and summing the denominator
//   DIV   | dividing e[idx] by the denominator
//   OUT   | presenting element idx until the consumer takes it
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int N    = 8,
  parameter int IW   = 17,
  parameter int FRAC = 12,
  parameter int E    = 16,
  parameter int OW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [N*IW-1:0]         i_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [OW-1:0]           o_data,
  output logic [idx_width(N)-1:0] o_idx,
  output logic                    o_last,
  output logic                    busy
);

  localparam int DENW = den_width(N, E);
  localparam int IDXW = idx_width(N);
  localparam int KW   = IW - FRAC;
  localparam logic [E:0]      MANT_ONE = (E + 1)'(1) << E;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  state_e                state_q, state_d;
  logic signed [IW-1:0]  vec_q [N];
  logic signed [IW-1:0]  vec_d [N];
  logic [E:0]            e_q [N];
  logic [E:0]            e_d [N];
  logic [IDXW-1:0]       idx_q, idx_d;
  logic signed [IW-1:0]  max_q, max_d;
  logic [DENW-1:0]       den_q, den_d;
  logic [OW-1:0]         o_data_q, o_data_d;
  logic [IDXW-1:0]       o_idx_q, o_idx_d;
  logic                  o_last_q, o_last_d;

  logic signed [IW-1:0]  x_cur;
  logic [IW-1:0]         diff;
  logic [KW-1:0]         k_sh;
  logic [FRAC-1:0]       f_part;
  logic [E:0]            mant;
  logic [E:0]            e_new;

  logic                  div_start, div_busy, div_done;
  logic [OW-1:0]         div_quo;

  // Piecewise-linear 2^-(d): integer part of d shifts, fraction bends the mantissa.
  always_comb begin
    x_cur  = vec_q[idx_q];
    diff   = IW'(max_q - x_cur);
    k_sh   = diff[IW-1:FRAC];
    f_part = diff[FRAC-1:0];
    mant   = MANT_ONE - ((E + 1)'(f_part) << (E - FRAC - 1));
    e_new  = (32'(k_sh) > E) ? '0 : (mant >> k_sh);
  end

  // Next-state, datapath updates and output capture.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    e_d       = e_q;
    idx_d     = idx_q;
    max_d     = max_q;
    den_d     = den_q;
    o_data_d  = o_data_q;
    o_idx_d   = o_idx_q;
    o_last_d  = o_last_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          for (int k = 0; k < N; k++) begin
            vec_d[k] = i_data[k*IW +: IW];
          end
          idx_d   = '0;
          den_d   = '0;
          state_d = MAX;
        end
      end
      MAX: begin
        if (idx_q == '0 || x_cur > max_q) begin
          max_d = x_cur;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = EXP;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      EXP: begin
        e_d[idx_q] = e_new;
        den_d      = den_q + DENW'(e_new);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DIV;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DIV: begin
        div_start = !div_busy;
        if (div_done) begin
          o_data_d = div_quo;
          o_idx_d  = idx_q;
          o_last_d = (idx_q == IDX_LAST);
          state_d  = OUT;
        end
      end
      OUT: begin
        if (o_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = DIV;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, register files, accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int k = 0; k < N; k++) begin
        vec_q[k] <= '0;
        e_q[k]   <= '0;
      end
      idx_q    <= '0;
      max_q    <= '0;
      den_q    <= '0;
      o_data_q <= '0;
      o_idx_q  <= '0;
      o_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      e_q      <= e_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      den_q    <= den_d;
      o_data_q <= o_data_d;
      o_idx_q  <= o_idx_d;
      o_last_q <= o_last_d;
    end
  end

  softmax_div_serial #(
    .NW(E + 1),
    .DW(DENW),
    .QW(OW)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .num  (e_q[idx_q]),
    .den  (den_q),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == OUT);
  assign busy    = (state_q != IDLE);
  assign o_data  = o_data_q;
  assign o_idx   = o_idx_q;
  assign o_last  = o_last_q;

endmodule

// File: doc/softmax_stream.md
# softmax_stream

Sequential, parametrised softmax engine. It accepts one N-element signed fixed-point vector per handshake and computes a base-2 softmax with max-subtraction. It time-multiplexes a single exponent datapath and a single serial divider, and streams the N normalised probabilities out one element per handshake with backpressure. It succeeds the fully combinational fixed-5-input softmax path, and targets attention-score normalisation where area matters more than throughput.

## Interface
- N, 8: vector length (channels), ≥1
- IW, 17: input width, signed two's complement
- FRAC, 12: fractional bits of input, FRAC < IW, FRAC+1 ≤ E
- E, 16: exponent mantissa width; e_i range [0, 2^E]
- OW, 16: output width, unsigned Q0.OW probability
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input vector valid
- i_ready  out  1  engine can accept a vector
- i_data  in  N*IW  packed vector, element k at bits [k*IW +: IW]
- o_valid  out  1  output element valid
- o_ready  in  1  consumer accepts output element
- o_data  out  OW  probability of element o_idx
- o_idx  out  max(1,$clog2(N))  element index
- o_last  out  1  high with o_valid on element N-1
- busy  out  1  high in every state except IDLE

## Operation
- Caller pre-scales scores by log2(e); block computes p_i = 2^(x_i) / Σ 2^(x_j) with approximations below.
- States: IDLE → MAX → EXP → DIV → OUT → (DIV for next element | IDLE).
- IDLE: i_ready=1. On i_valid&&i_ready, latch i_data into vector register and go to MAX.
- MAX: one element per cycle, N cycles; signed compare; running max starts at element 0; ties keep earlier value.
- EXP: one element per cycle, N cycles; d = max − x_i (unsigned, IW bits); k = d >> FRAC; f = d[FRAC-1:0]; mant = 2^E − (f << (E−FRAC−1)); e_i = (k > E) ? 0 : mant >> k. Store e_i (E+1 bits) and accumulate den (E+1+$clog2(N) bits, no overflow possible). The max element always yields e=2^E, so den ≥ 2^E.
- DIV: restoring divider, numerator e_i·2^OW, divisor den, OW+1 quotient bits over OW cycles after 1 load cycle. Result saturates to 2^OW−1 if quotient ≥ 2^OW (e_i == den).
- OUT: o_valid=1 holding o_data/o_idx/o_last stable until o_ready. On handshake: if idx==N−1 go to IDLE, else idx+1 and go to DIV.
- o_ready is ignored outside OUT; i_valid is ignored outside IDLE.
- rst asserted at any time: state→IDLE, idx/max/den cleared, any in-flight vector discarded, no partial output emitted.

## Timing
- Reset values: i_ready=1 (IDLE), o_valid=0, o_data=0, o_idx=0, o_last=0, busy=0.
- Input handshake at edge T: MAX occupies T+1..T+N; EXP occupies T+N+1..T+2N; DIV occupies T+2N+1..T+2N+OW+1; o_valid is first high in cycle T+2N+OW+2.
- With o_ready held high: each further element adds OW+2 cycles. The vector completes in 2N + N·(OW+2) cycles, after which the engine returns to IDLE, and i_ready rises in the cycle after the last output handshake.
- Outputs are registered; o_data changes only on entry to OUT.
- No input buffering: a new vector is never accepted while busy.

## Structure
- Package softmax_pkg: state enum (IDLE, MAX, EXP, DIV, OUT), width helpers for den width and index width, saturation constant.
- Sub-module softmax_div_serial: start/done restoring divider, parameters NW, DW, QW; owns its cycle counter. The top level holds the FSM, vector/e_i register files, max and den accumulators.

## Test plan
- N=8, all x_i=0, o_ready=1 → every o_data=8192 (2^16/8), o_last only on idx 7, first o_valid at T+2N+OW+2=34.
- N=8, x_0=4096 (1.0), others 0 → e_0=65536, e_others=32768; den=294912; o_data[0]=14563, others 7281.
- N=8, x_3=0x0FFFF (max positive), others −65536 → k>E for others, e=0; o_data[3]=65535 (saturated), others 0.
- Random vectors with random o_ready stalls → o_data/o_idx stable while stalled, sequence matches bit-exact reference model, i_ready low until final handshake.
- rst pulsed mid-DIV of element 4 → o_valid=0, i_ready=1 next cycle; the next vector produces correct results with no stale elements.
- N=1, any x → single output 65535 with o_last=1.
